// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder engine.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/fa_cell.sv
// Single 1-bit full adder; the only arithmetic element of the serial adder.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell walks LSB-first over latched operands,
// producing sum, carry-out and signed overflow WIDTH+1 cycles after start.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             overflow
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic             carry;
  logic             c_msb;
  logic [CNT_W-1:0] cnt;
  logic             cell_s;
  logic             cell_cout;
  logic             last_bit;
  logic             load;

  fa_cell u_fa_cell (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry),
    .s    (cell_s),
    .cout (cell_cout)
  );

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // DONE accepts a new start exactly like IDLE so adds can run back-to-back.
  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          next_state = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (last_bit) begin
          next_state = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          load       = 1'b1;
          next_state = SHIFT;
        end else begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // The carry leaving bit WIDTH-2 is the carry into the MSB, needed for overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr     <= '0;
      b_sr     <= '0;
      sum_sr   <= '0;
      carry    <= 1'b0;
      c_msb    <= 1'b0;
      cnt      <= '0;
      s        <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else if (load) begin
      a_sr  <= a;
      b_sr  <= b;
      carry <= cin;
      cnt   <= '0;
    end else if (state == SHIFT) begin
      sum_sr <= {cell_s, sum_sr[WIDTH-1:1]};
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      carry  <= cell_cout;
      cnt    <= cnt + 1'b1;
      if (cnt == CNT_W'(WIDTH - 2)) begin
        c_msb <= cell_cout;
      end
      if (last_bit) begin
        s        <= {cell_s, sum_sr[WIDTH-1:1]};
        cout     <= cell_cout;
        overflow <= c_msb ^ cell_cout;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: WIDTH=4 directed/exhaustive and WIDTH=8 random.
module tb_serial_adder_ctrl;

  typedef struct {
    int s;
    int cout;
    int ovf;
    int due;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       start4, start8;
  logic [3:0] a4, b4;
  logic [7:0] a8, b8;
  logic       cin4, cin8;
  logic       busy4, done4, cout4, ovf4;
  logic       busy8, done8, cout8, ovf8;
  logic [3:0] s4;
  logic [7:0] s8;

  int   cyc = 0;
  int   total = 0;
  int   passed = 0;
  exp_t q4[$];
  exp_t q8[$];
  exp_t e4, e8;

  serial_adder_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .s(s4), .cout(cout4), .overflow(ovf4)
  );

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .s(s8), .cout(cout8), .overflow(ovf8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain integer arithmetic and signed range test.
  function automatic exp_t refModel(input int w, input int av, input int bv,
                                    input int cv, input int due);
    exp_t r;
    int   full, sa, sb, ss;
    full  = av + bv + cv;
    r.s   = full % (1 << w);
    r.cout = full / (1 << w);
    sa    = (av >= (1 << (w - 1))) ? av - (1 << w) : av;
    sb    = (bv >= (1 << (w - 1))) ? bv - (1 << w) : bv;
    ss    = sa + sb + cv;
    r.ovf = ((ss > (1 << (w - 1)) - 1) || (ss < -(1 << (w - 1)))) ? 1 : 0;
    r.due = due;
    return r;
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    total++;
    if (act == exp) begin
      passed++;
    end else begin
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called #1 after a rising edge; the start cycle is the current one.
  task automatic applyStimulus(input bit wide, input int av, input int bv, input int cv);
    if (wide) begin
      a8 = 8'(av); b8 = 8'(bv); cin8 = 1'(cv); start8 = 1'b1;
      q8.push_back(refModel(8, av % 256, bv % 256, cv % 2, cyc + 9));
    end else begin
      a4 = 4'(av); b4 = 4'(bv); cin4 = 1'(cv); start4 = 1'b1;
      q4.push_back(refModel(4, av % 16, bv % 16, cv % 2, cyc + 5));
    end
    @(posedge clk); #1;
    start4 = 1'b0;
    start8 = 1'b0;
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while ((q4.size() + q8.size() > 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    checkOutput("drain", q4.size() + q8.size(), 0);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (!rst && done4) begin
      checkOutput("done4_pending", int'(q4.size() > 0), 1);
      checkOutput("busy4_at_done", int'(busy4), 0);
      if (q4.size() > 0) begin
        e4 = q4.pop_front();
        checkOutput("s4", int'(s4), e4.s);
        checkOutput("cout4", int'(cout4), e4.cout);
        checkOutput("ovf4", int'(ovf4), e4.ovf);
        checkOutput("done4_cycle", cyc, e4.due);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && done8) begin
      checkOutput("done8_pending", int'(q8.size() > 0), 1);
      if (q8.size() > 0) begin
        e8 = q8.pop_front();
        checkOutput("s8", int'(s8), e8.s);
        checkOutput("cout8", int'(cout8), e8.cout);
        checkOutput("ovf8", int'(ovf8), e8.ovf);
        checkOutput("done8_cycle", cyc, e8.due);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    start4 = 1'b0; start8 = 1'b0;
    a4 = '0; b4 = '0; cin4 = 1'b0;
    a8 = '0; b8 = '0; cin8 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_busy", int'(busy4), 0);
    checkOutput("rst_done", int'(done4), 0);
    checkOutput("rst_s", int'(s4), 0);
    checkOutput("rst_cout", int'(cout4), 0);
    checkOutput("rst_ovf", int'(ovf4), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] directed vectors");
    applyStimulus(0, 5, 3, 0);
    waitDrain(20);
    applyStimulus(0, 15, 1, 0);
    waitDrain(20);
    applyStimulus(0, 7, 0, 1);
    waitDrain(20);

    $display("[TB] start while busy is ignored");
    applyStimulus(0, 5, 3, 0);
    @(posedge clk); #1;
    checkOutput("busy_in_shift", int'(busy4), 1);
    start4 = 1'b1; a4 = 4'hF; b4 = 4'hE; cin4 = 1'b1;
    @(posedge clk); #1;
    a4 = 4'h9; b4 = 4'h6;
    @(posedge clk); #1;
    start4 = 1'b0;
    waitDrain(20);
    repeat (6) @(posedge clk);
    #1;

    $display("[TB] reset in the middle of SHIFT");
    applyStimulus(0, 9, 9, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    q4.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_busy", int'(busy4), 0);
    checkOutput("midrst_done", int'(done4), 0);
    checkOutput("midrst_s", int'(s4), 0);
    checkOutput("midrst_cout", int'(cout4), 0);
    checkOutput("midrst_ovf", int'(ovf4), 0);
    @(posedge clk); #1;
    applyStimulus(0, 6, 7, 1);
    waitDrain(20);

    $display("[TB] start held high across done");
    a4 = 4'h3; b4 = 4'hA; cin4 = 1'b0; start4 = 1'b1;
    q4.push_back(refModel(4, 3, 10, 0, cyc + 5));
    @(posedge clk); #1;
    a4 = 4'hC; b4 = 4'hC; cin4 = 1'b1;
    q4.push_back(refModel(4, 12, 12, 1, cyc + 4 + 5));
    repeat (5) @(posedge clk);
    #1;
    start4 = 1'b0;
    waitDrain(30);

    $display("[TB] exhaustive WIDTH=4");
    for (int av = 0; av < 16; av++) begin
      for (int bv = 0; bv < 16; bv++) begin
        for (int cv = 0; cv < 2; cv++) begin
          applyStimulus(0, av, bv, cv);
          repeat (4) @(posedge clk);
          #1;
        end
      end
    end
    waitDrain(20);

    $display("[TB] random WIDTH=8");
    for (int i = 0; i < 1000; i++) begin
      applyStimulus(1, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                    int'($urandom_range(0, 1)));
      repeat (8) @(posedge clk);
      #1;
    end
    waitDrain(30);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
